// File: rtl/arb_grant_mux.sv
// Per-requester one-beat buffers feeding an external arbiter; the granted beat
// moves into a registered valid/ready output stage tagged with its requester index.
module arb_grant_mux #(
  parameter  int N  = 32,
  parameter  int DW = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid_i,
  output logic [N-1:0]    in_ready_o,
  input  logic [N*DW-1:0] in_data_i,
  output logic [N-1:0]    req_o,
  input  logic [N-1:0]    gnt_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   out_data_o,
  output logic [IW-1:0]   out_id_o,
  output logic            err_o
);

  logic [N-1:0]  r_slotValid;
  logic [DW-1:0] r_slotData [N];
  logic          r_outValid;
  logic [DW-1:0] r_outData;
  logic [IW-1:0] r_outId;
  logic          r_err;

  logic          w_outFree;
  logic [N-1:0]  w_req;
  logic [N-1:0]  w_gntMinus1;
  logic          w_gntAny;
  logic          w_gntOneHot;
  logic          w_gntOk;
  logic          w_gntBad;
  logic [N-1:0]  w_drain;
  logic [N-1:0]  w_inReady;
  logic [N-1:0]  w_load;
  logic [DW-1:0] w_selData;
  logic [IW-1:0] w_selId;

  // Requests are withheld entirely while the output register is stalled.
  assign w_outFree   = ~r_outValid | out_ready_i;
  assign w_req       = r_slotValid & {N{w_outFree}};
  assign w_gntMinus1 = gnt_i - N'(1);
  assign w_gntAny    = |gnt_i;
  assign w_gntOneHot = w_gntAny && ((gnt_i & w_gntMinus1) == '0);
  assign w_gntOk     = w_outFree && w_gntOneHot && ((gnt_i & ~w_req) == '0);
  assign w_gntBad    = w_gntAny && !w_gntOk;
  assign w_drain     = gnt_i & {N{w_gntOk}};
  assign w_inReady   = ~r_slotValid | w_drain;
  assign w_load      = in_valid_i & w_inReady;

  always_comb begin
    w_selData = '0;
    w_selId   = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_i[i]) begin
        w_selData = w_selData | r_slotData[i];
        w_selId   = w_selId | IW'(i);
      end
    end
  end

  // A refill takes precedence over a drain so same-cycle drain+refill keeps the new beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slotValid <= '0;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outId     <= '0;
      r_err       <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_load[i]) begin
          r_slotValid[i] <= 1'b1;
        end else if (w_drain[i]) begin
          r_slotValid[i] <= 1'b0;
        end
      end
      if (w_gntOk) begin
        r_outValid <= 1'b1;
        r_outData  <= w_selData;
        r_outId    <= w_selId;
      end else if (out_ready_i) begin
        r_outValid <= 1'b0;
      end
      r_err <= r_err | w_gntBad;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_load[i]) begin
        r_slotData[i] <= in_data_i[i*DW +: DW];
      end
    end
  end

  assign in_ready_o  = w_inReady;
  assign req_o       = w_req;
  assign out_valid_o = r_outValid;
  assign out_data_o  = r_outData;
  assign out_id_o    = r_outId;
  assign err_o       = r_err;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Directed bench for arb_grant_mux (N=4, DW=8) with a fixed-priority arbiter model
// and an override path for injecting faulty grants.
module tb_arb_grant_mux;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    inValid;
  logic [N-1:0]    inReady;
  logic [N*DW-1:0] inData;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            outValid;
  logic            outReady;
  logic [DW-1:0]   outData;
  logic [IW-1:0]   outId;
  logic            err;

  logic            forceEn;
  logic [N-1:0]    forceGnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Fixed-priority arbiter: lowest-index request wins, unless a fault is being injected.
  assign gnt = forceEn ? forceGnt : (req & (~req + 4'd1));

  arb_grant_mux #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_data_i   (inData),
    .req_o       (req),
    .gnt_i       (gnt),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (outData),
    .out_id_o    (outId),
    .err_o       (err)
  );

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [7:0] expData, input logic [1:0] expId);
    checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_data"}, 32'(outData), 32'(expData));
    checkOutput({tag, "_id"}, 32'(outId), 32'(expId));
  endtask

  initial begin
    reset    = 1'b1;
    inValid  = '0;
    inData   = '0;
    outReady = 1'b1;
    forceEn  = 1'b0;
    forceGnt = '0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req", 32'(req), 32'd0);
    checkOutput("rst_ready", 32'(inReady), 32'hF);
    checkOutput("rst_data", 32'(outData), 32'd0);
    checkOutput("rst_id", 32'(outId), 32'd0);

    // Single beat on requester 2: two cycles input to output, exactly one beat.
    inValid = 4'b0100;
    inData[2*DW +: DW] = 8'hA5;
    applyStimulus();
    inValid = '0;
    #1;
    checkOutput("single_req", 32'(req), 32'h4);
    checkOutput("single_notyet", 32'(outValid), 32'd0);
    applyStimulus();
    checkBeat("single_beat", 8'hA5, 2'd2);
    applyStimulus();
    checkOutput("single_once", 32'(outValid), 32'd0);

    // All four load together and drain back to back in priority order.
    inValid = 4'b1111;
    inData  = 32'h13121110;
    applyStimulus();
    inValid = '0;
    #1;
    checkOutput("burst_req", 32'(req), 32'hF);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkBeat($sformatf("burst%0d", k), 8'(8'h10 + k), 2'(k));
    end
    applyStimulus();
    checkOutput("burst_end", 32'(outValid), 32'd0);

    // Stall with all slots full.
    inValid = 4'b1111;
    inData  = 32'h23222120;
    applyStimulus();
    inValid = '0;
    applyStimulus();
    checkBeat("stall_first", 8'h20, 2'd0);
    outReady = 1'b0;
    inValid  = 4'b0001;
    inData[0 +: DW] = 8'h24;
    #1;
    checkOutput("stall_refill_ready", 32'(inReady), 32'h1);
    checkOutput("stall_refill_req", 32'(req), 32'd0);
    applyStimulus();
    inValid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkBeat($sformatf("stall%0d", k), 8'h20, 2'd0);
      checkOutput($sformatf("stall%0d_req", k), 32'(req), 32'd0);
      checkOutput($sformatf("stall%0d_ready", k), 32'(inReady), 32'd0);
      applyStimulus();
    end
    outReady = 1'b1;
    #1;
    checkOutput("release_req", 32'(req), 32'hF);
    applyStimulus();
    checkBeat("release0", 8'h24, 2'd0);
    applyStimulus();
    checkBeat("release1", 8'h21, 2'd1);
    applyStimulus();
    checkBeat("release2", 8'h22, 2'd2);
    applyStimulus();
    checkBeat("release3", 8'h23, 2'd3);
    applyStimulus();
    checkOutput("release_end", 32'(outValid), 32'd0);

    // Requester 0 streams continuously and starves requester 1.
    inValid = 4'b0011;
    inData[0 +: DW]  = 8'h40;
    inData[DW +: DW] = 8'h99;
    applyStimulus();
    inValid = 4'b0001;
    inData[0 +: DW] = 8'h41;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checkBeat($sformatf("stream%0d", k), 8'(8'h40 + k), 2'd0);
      checkOutput($sformatf("stream%0d_starve", k), 32'(inReady[1]), 32'd0);
      inData[0 +: DW] = 8'(8'h42 + k);
    end
    inValid = '0;
    applyStimulus();
    checkBeat("stream_last", 8'h46, 2'd0);
    applyStimulus();
    checkBeat("stream_starved", 8'h99, 2'd1);
    applyStimulus();
    checkOutput("stream_end", 32'(outValid), 32'd0);

    // Fault: two-hot grant over two pending requests.
    forceEn  = 1'b1;
    forceGnt = '0;
    inValid  = 4'b0011;
    inData[0 +: DW]  = 8'h50;
    inData[DW +: DW] = 8'h51;
    applyStimulus();
    inValid = '0;
    #1;
    checkOutput("fault_req", 32'(req), 32'h3);
    forceGnt = 4'b0011;
    #1;
    checkOutput("fault_nodrain_ready", 32'(inReady), 32'hC);
    applyStimulus();
    checkOutput("fault_err", 32'(err), 32'd1);
    checkOutput("fault_nobeat", 32'(outValid), 32'd0);
    forceGnt = '0;
    applyStimulus();
    checkOutput("fault_sticky", 32'(err), 32'd1);
    checkOutput("fault_slots_kept", 32'(req), 32'h3);
    checkOutput("fault_nobeat2", 32'(outValid), 32'd0);
    reset = 1'b1;
    applyStimulus();
    reset   = 1'b0;
    forceEn = 1'b0;
    #1;
    checkOutput("rst2_err", 32'(err), 32'd0);
    checkOutput("rst2_valid", 32'(outValid), 32'd0);
    checkOutput("rst2_data", 32'(outData), 32'd0);
    checkOutput("rst2_id", 32'(outId), 32'd0);
    checkOutput("rst2_req", 32'(req), 32'd0);
    checkOutput("rst2_ready", 32'(inReady), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
